// File: rtl/shift_pkg.sv
// Shared constants and opcode encoding for the shift pipeline.
// Rotate opcodes are only decoded when SHIFT_PIPE_ROTATE_EN is defined.
package shift_pkg;

  localparam int N_DEF = 16;
  localparam int C_DEF = 4;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } op_e;

endpackage

// File: rtl/shift_core.sv
// Combinational N-bit shifter/rotator between the two pipeline stages.
// Rotates exist only with SHIFT_PIPE_ROTATE_EN; otherwise they decode as illegal.
import shift_pkg::*;

module shift_core #(
  parameter int N = N_DEF,
  parameter int C = C_DEF
) (
  input  logic [N-1:0] data,
  input  logic [C-1:0] cnt,
  input  logic [2:0]   op,
  output logic [N-1:0] res,
  output logic         err
);

  always_comb begin
    res = data;
    err = 1'b0;
    unique case (1'b1)
      (op == OP_SLL): res = data << cnt;
      (op == OP_SRL): res = data >> cnt;
      (op == OP_SRA): res = N'($signed(data) >>> cnt);
`ifdef SHIFT_PIPE_ROTATE_EN
      // A shift by N yields zero, so cnt == 0 passes data through.
      (op == OP_ROL): res = (data << cnt) | (data >> (N - int'(cnt)));
      (op == OP_ROR): res = (data >> cnt) | (data << (N - int'(cnt)));
`endif
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_pipe.sv
// Two-stage valid/ready shift pipeline: S1 holds operands, S2 the result.
// Define SHIFT_PIPE_ROTATE_EN to enable ROL/ROR.
import shift_pkg::*;

module shift_pipe #(
  parameter int N = N_DEF,
  parameter int C = C_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [C-1:0] in_cnt,
  input  logic [2:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_zero,
  output logic         out_err
);

  logic         s1_v;
  logic [N-1:0] s1_data;
  logic [C-1:0] s1_cnt;
  logic [2:0]   s1_op;
  logic         s2_v;
  logic         s2_adv;
  logic [N-1:0] res;
  logic         err;

  assign s2_adv    = !s2_v || out_ready;
  assign in_ready  = !s1_v || s2_adv;
  assign out_valid = s2_v;

  shift_core #(
    .N(N),
    .C(C)
  ) u_core (
    .data(s1_data),
    .cnt (s1_cnt),
    .op  (s1_op),
    .res (res),
    .err (err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      s1_data  <= '0;
      s1_cnt   <= '0;
      s1_op    <= '0;
      out_data <= '0;
      out_zero <= 1'b0;
      out_err  <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_v <= in_valid;
      end
      if (in_valid && in_ready) begin
        s1_data <= in_data;
        s1_cnt  <= in_cnt;
        s1_op   <= in_op;
      end
      if (s2_adv) begin
        s2_v <= s1_v;
        if (s1_v) begin
          out_data <= res;
          out_zero <= (res == '0);
          out_err  <= err;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Directed self-checking bench for shift_pipe.
// Rotate expectations follow SHIFT_PIPE_ROTATE_EN.
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_zero;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_cnt   (in_cnt),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_zero (out_zero),
    .out_err  (out_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op,
                       input logic [15:0] d, input logic [3:0] c);
    in_valid = v;
    in_op    = op;
    in_data  = d;
    in_cnt   = c;
  endtask

  task automatic single(input string tag, input logic [2:0] op,
                        input logic [15:0] d, input logic [3:0] c,
                        input logic [15:0] exp_d, input logic exp_e);
    @(negedge clk);
    out_ready = 1'b1;
    drive(1'b1, op, d, c);
    chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 3'b000, 16'hDEAD, 4'hF);
    chk({tag, ".lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, ".vld"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"}, 32'(out_data), 32'(exp_d));
    chk({tag, ".err"}, 32'(out_err), 32'(exp_e));
    chk({tag, ".zero"}, 32'(out_zero), 32'(exp_d == 16'h0));
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 3'b000, 16'h0, 4'h0);
    repeat (3) @(negedge clk);
    chk("rst.vld", 32'(out_valid), 32'd0);
    chk("rst.data", 32'(out_data), 32'd0);
    chk("rst.zero", 32'(out_zero), 32'd0);
    chk("rst.err", 32'(out_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.rdy", 32'(in_ready), 32'd1);

    single("sll1", 3'b000, 16'h8001, 4'd1, 16'h0002, 1'b0);
    single("sra15", 3'b010, 16'h8000, 4'd15, 16'hFFFF, 1'b0);
    single("srl15", 3'b001, 16'h8000, 4'd15, 16'h0001, 1'b0);
    single("sll0", 3'b000, 16'h0001, 4'd0, 16'h0001, 1'b0);
    single("srlz", 3'b001, 16'h0001, 4'd1, 16'h0000, 1'b0);
    single("srapos", 3'b010, 16'h4000, 4'd14, 16'h0001, 1'b0);
`ifdef SHIFT_PIPE_ROTATE_EN
    single("rol4", 3'b011, 16'h8001, 4'd4, 16'h0018, 1'b0);
    single("ror1", 3'b100, 16'h0001, 4'd1, 16'h8000, 1'b0);
    single("rol0", 3'b011, 16'hA5C3, 4'd0, 16'hA5C3, 1'b0);
`else
    single("rol4", 3'b011, 16'h8001, 4'd4, 16'h8001, 1'b1);
    single("ror1", 3'b100, 16'h0001, 4'd1, 16'h0001, 1'b1);
`endif
    single("ill7", 3'b111, 16'h1234, 4'd3, 16'h1234, 1'b1);
    single("ill5z", 3'b101, 16'h0000, 4'd2, 16'h0000, 1'b1);

    // Eight back-to-back ops; result j-2 visible at step j.
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk($sformatf("b2b.vld%0d", j), 32'(out_valid), 32'(j >= 2));
      if (j >= 2)
        chk($sformatf("b2b.data%0d", j), 32'(out_data),
            32'((j - 1) << 1));
      if (j < 8) begin
        drive(1'b1, 3'b000, 16'(j + 1), 4'd1);
        chk($sformatf("b2b.rdy%0d", j), 32'(in_ready), 32'd1);
      end else begin
        drive(1'b0, 3'b000, 16'h0, 4'h0);
      end
    end

    // Backpressure: three ops offered while out_ready is low.
    @(negedge clk);
    chk("bp.empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 16'h0001, 4'd1);
    @(negedge clk);
    chk("bp.rdyB", 32'(in_ready), 32'd1);
    drive(1'b1, 3'b001, 16'h0100, 4'd4);
    @(negedge clk);
    drive(1'b1, 3'b010, 16'h8000, 4'd1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp.stall%0d", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp.hold%0d", k), 32'(out_data), 32'h0002);
      chk($sformatf("bp.vld%0d", k), 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.rdyup", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 3'b000, 16'h0, 4'h0);
    chk("bp.B", 32'(out_data), 32'h0010);
    chk("bp.Bv", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("bp.C", 32'(out_data), 32'hC000);
    chk("bp.Cv", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("bp.done", 32'(out_valid), 32'd0);

    // Reset with both stages full, racing in_valid and out_ready.
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 16'h00F0, 4'd2);
    @(negedge clk);
    drive(1'b1, 3'b000, 16'h000F, 4'd1);
    @(negedge clk);
    chk("mr.full", 32'(out_valid), 32'd1);
    chk("mr.fullrdy", 32'(in_ready), 32'd0);
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 3'b000, 16'h5555, 4'd1);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 3'b000, 16'h0, 4'h0);
    chk("mr.vld", 32'(out_valid), 32'd0);
    chk("mr.data", 32'(out_data), 32'd0);
    chk("mr.zero", 32'(out_zero), 32'd0);
    chk("mr.err", 32'(out_err), 32'd0);
    chk("mr.rdy", 32'(in_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("mr.stale%0d", k), 32'(out_valid), 32'd0);
    end

    single("post", 3'b001, 16'hF000, 4'd4, 16'h0F00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 SHALL have parameter N, default 16, data width in bits.
REQ-002 SHALL have parameter C, default 4, shift-count width in bits (C = log2 N).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream offers an operation.
REQ-006 SHALL have port in_ready  output  1  block accepts the operation this cycle.
REQ-007 SHALL have port in_data  input  N  operand.
REQ-008 SHALL have port in_cnt  input  C  shift amount, 0..N-1.
REQ-009 SHALL have port in_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 illegal.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  downstream consumes the result this cycle.
REQ-012 SHALL have port out_data  output  N  shifted result.
REQ-013 SHALL have port out_zero  output  1  out_data == 0.
REQ-014 SHALL have port out_err  output  1  illegal or compiled-out opcode.

Function
REQ-015 SHALL accept an operation when in_valid && in_ready, and transfer a result when out_valid && out_ready.
REQ-016 SHALL be a two-stage pipeline: S1 registers in_data/in_cnt/in_op plus a valid bit; S2 registers the computed result, out_zero, out_err plus a valid bit.
REQ-017 SHALL present a result on out_valid exactly 2 cycles after acceptance when out_ready stays high; throughput 1 op/cycle.
REQ-018 SHALL advance S2 when S2 is empty or out_ready is high; S1 advances into S2 under the same condition.
REQ-019 SHALL drive in_ready = !S1.valid || S2 advancing (combinational from out_ready, no added bubble).
REQ-020 SHALL hold out_data, out_zero, out_err stable while out_valid && !out_ready.
REQ-021 SHALL never drop, duplicate or reorder operations.
REQ-022 SHALL compute SLL: fill zeros from bit 0; SRL: fill zeros from bit N-1; SRA: fill with copies of in_data[N-1].
REQ-023 SHALL compute ROL/ROR as circular rotates, with bits leaving one end re-entering the other.
REQ-024 SHALL return in_data unchanged for in_cnt = 0 for every legal op.
REQ-025 SHALL, for an illegal op, return out_data = in_data, out_err = 1, out_zero computed from out_data.
REQ-026 SHALL treat in_data/in_cnt/in_op as don't-care when in_valid is low; no state changes on them.

Reset
REQ-027 SHALL, on rst, clear both stage valid bits and set out_data = 0, out_zero = 0, out_err = 0; in_ready = 1 from the first cycle after rst falls.
REQ-028 SHALL discard in-flight operations when rst asserts mid-operation; no result appears for them.
REQ-029 SHALL give rst priority over a simultaneous in_valid or out_ready.

Configuration
REQ-030 SHALL compile ROL/ROR support in when macro SHIFT_PIPE_ROTATE_EN is defined.
REQ-031 SHALL, without SHIFT_PIPE_ROTATE_EN, treat ROL/ROR as illegal per REQ-025, with no rotate logic synthesised.

Structure
REQ-032 SHALL take opcode constants (SLL, SRL, SRA, ROL, ROR) from shared package shift_pkg, with the default N/C constants.
REQ-033 SHALL place the combinational N-bit shift/rotate datapath in sub-module shift_core, instantiated between S1 and S2; pipeline control SHALL stay in shift_pipe.

Verification
REQ-034 SHALL cover: SLL in_data=16'h8001, cnt=1 -> out_data=16'h0002, out_zero=0, out_valid 2 cycles after accept.
REQ-035 SHALL cover: SRA 16'h8000 cnt=15 -> 16'hFFFF; SRL 16'h8000 cnt=15 -> 16'h0001; SLL 16'h0001 cnt=0 -> 16'h0001.
REQ-036 SHALL cover: ROL 16'h8001 cnt=4 -> 16'h0018 with the macro defined; without it -> out_data=16'h8001, out_err=1.
REQ-037 SHALL cover: back-to-back 8 ops with out_ready=1 -> 8 results on consecutive cycles, in order.
REQ-038 SHALL cover: out_ready held low 5 cycles with 3 ops offered -> in_ready falls after 2 accepts, out_data stable, all 3 delivered in order once out_ready rises.
REQ-039 SHALL cover: rst pulsed with both stages full -> out_valid=0 next cycle, out_data=0, no stale result later; op 3'b111 -> out_err=1.
